// File: rtl/arith_reservation_station_if.sv
// Dispatch, CDB, flush and FU-issue signals of the arithmetic reservation station.
// The slave modport is the station; the master modport is its environment.
interface arith_reservation_station_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ROB_SIZE = 256
);
  localparam int unsigned TW = $clog2(ROB_SIZE);

  logic            disp_valid;
  logic            disp_ready;
  logic [2:0]      disp_arith_type;
  logic            disp_additional_info;
  logic [TW-1:0]   disp_rob_entry;
  logic            disp_rs1_rdy;
  logic [TW-1:0]   disp_rs1_tag;
  logic [XLEN-1:0] disp_rs1_val;
  logic            disp_rs2_rdy;
  logic [TW-1:0]   disp_rs2_tag;
  logic [XLEN-1:0] disp_rs2_val;

  logic            cdb_valid;
  logic [TW-1:0]   cdb_rob_entry;
  logic [XLEN-1:0] cdb_value;

  logic            flush;

  logic            fu_ready;
  logic            issue_valid;
  logic [2:0]      issue_arith_type;
  logic            issue_additional_info;
  logic [TW-1:0]   issue_rob_entry;
  logic [XLEN-1:0] issue_rs1;
  logic [XLEN-1:0] issue_rs2;

  modport master (
    output disp_valid, disp_arith_type, disp_additional_info, disp_rob_entry,
           disp_rs1_rdy, disp_rs1_tag, disp_rs1_val, disp_rs2_rdy, disp_rs2_tag, disp_rs2_val,
           cdb_valid, cdb_rob_entry, cdb_value, flush, fu_ready,
    input  disp_ready, issue_valid, issue_arith_type, issue_additional_info, issue_rob_entry,
           issue_rs1, issue_rs2
  );

  modport slave (
    input  disp_valid, disp_arith_type, disp_additional_info, disp_rob_entry,
           disp_rs1_rdy, disp_rs1_tag, disp_rs1_val, disp_rs2_rdy, disp_rs2_tag, disp_rs2_val,
           cdb_valid, cdb_rob_entry, cdb_value, flush, fu_ready,
    output disp_ready, issue_valid, issue_arith_type, issue_additional_info, issue_rob_entry,
           issue_rs1, issue_rs2
  );
endinterface

// File: rtl/arith_reservation_station.sv
// Issue buffer for the arithmetic FU: holds dispatched ops, snoops the CDB for pending operands
// and issues the oldest fully-ready op through a registered issue stage.
module arith_reservation_station #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ROB_SIZE = 256,
  parameter int unsigned RS_DEPTH = 8
) (
  input logic                        clk,
  input logic                        rst,
  arith_reservation_station_if.slave bus
);
  localparam int unsigned TW = $clog2(ROB_SIZE);
  localparam int unsigned IW = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0] valid_q;
  logic [2:0]          type_q    [RS_DEPTH];
  logic                info_q    [RS_DEPTH];
  logic [TW-1:0]       rob_q     [RS_DEPTH];
  logic                rs1_rdy_q [RS_DEPTH];
  logic [TW-1:0]       rs1_tag_q [RS_DEPTH];
  logic [XLEN-1:0]     rs1_val_q [RS_DEPTH];
  logic                rs2_rdy_q [RS_DEPTH];
  logic [TW-1:0]       rs2_tag_q [RS_DEPTH];
  logic [XLEN-1:0]     rs2_val_q [RS_DEPTH];
  // older_q[i][j] set: entry i was dispatched before entry j
  logic [RS_DEPTH-1:0] older_q   [RS_DEPTH];

  logic            issue_valid_q;
  logic [2:0]      issue_type_q;
  logic            issue_info_q;
  logic [TW-1:0]   issue_rob_q;
  logic [XLEN-1:0] issue_rs1_q;
  logic [XLEN-1:0] issue_rs2_q;

  logic [RS_DEPTH-1:0] ready_vec;
  logic [RS_DEPTH-1:0] blocked_vec;
  logic [IW-1:0]       alloc_idx;
  logic                alloc_found;
  logic [IW-1:0]       sel_idx;
  logic                sel_found;
  logic                disp_fire;
  logic                issue_load;
  logic                issue_take;
  logic                rs1_cdb_hit;
  logic                rs2_cdb_hit;

  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    sel_idx     = '0;
    sel_found   = 1'b0;
    ready_vec   = '0;
    blocked_vec = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      ready_vec[i] = valid_q[i] & rs1_rdy_q[i] & rs2_rdy_q[i];
      if (!valid_q[i] && !alloc_found) begin
        alloc_idx   = IW'(i);
        alloc_found = 1'b1;
      end
    end
    // An entry is blocked when any older entry is also ready to go.
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      for (int unsigned j = 0; j < RS_DEPTH; j++) begin
        if (j != i && ready_vec[j] && older_q[j][i]) blocked_vec[i] = 1'b1;
      end
      if (ready_vec[i] && !blocked_vec[i] && !sel_found) begin
        sel_idx   = IW'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign bus.disp_ready = ~(&valid_q);
  assign disp_fire      = bus.disp_valid & bus.disp_ready;
  assign issue_load     = ~issue_valid_q | bus.fu_ready;
  assign issue_take     = issue_load & sel_found;
  assign rs1_cdb_hit    = bus.cdb_valid & (bus.disp_rs1_tag == bus.cdb_rob_entry);
  assign rs2_cdb_hit    = bus.cdb_valid & (bus.disp_rs2_tag == bus.cdb_rob_entry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_type_q  <= '0;
      issue_info_q  <= 1'b0;
      issue_rob_q   <= '0;
      issue_rs1_q   <= '0;
      issue_rs2_q   <= '0;
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        type_q[i]    <= '0;
        info_q[i]    <= 1'b0;
        rob_q[i]     <= '0;
        rs1_rdy_q[i] <= 1'b0;
        rs1_tag_q[i] <= '0;
        rs1_val_q[i] <= '0;
        rs2_rdy_q[i] <= 1'b0;
        rs2_tag_q[i] <= '0;
        rs2_val_q[i] <= '0;
        older_q[i]   <= '0;
      end
    end else if (bus.flush) begin
      valid_q       <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        if (bus.cdb_valid && valid_q[i] && !rs1_rdy_q[i] && rs1_tag_q[i] == bus.cdb_rob_entry) begin
          rs1_rdy_q[i] <= 1'b1;
          rs1_val_q[i] <= bus.cdb_value;
        end
        if (bus.cdb_valid && valid_q[i] && !rs2_rdy_q[i] && rs2_tag_q[i] == bus.cdb_rob_entry) begin
          rs2_rdy_q[i] <= 1'b1;
          rs2_val_q[i] <= bus.cdb_value;
        end
      end
      if (issue_take) valid_q[sel_idx] <= 1'b0;
      // alloc_idx is a free slot, so it never collides with sel_idx or a wakeup target.
      if (disp_fire) begin
        valid_q[alloc_idx]   <= 1'b1;
        type_q[alloc_idx]    <= bus.disp_arith_type;
        info_q[alloc_idx]    <= bus.disp_additional_info;
        rob_q[alloc_idx]     <= bus.disp_rob_entry;
        rs1_rdy_q[alloc_idx] <= bus.disp_rs1_rdy | rs1_cdb_hit;
        rs1_tag_q[alloc_idx] <= bus.disp_rs1_tag;
        rs1_val_q[alloc_idx] <= bus.disp_rs1_rdy ? bus.disp_rs1_val : bus.cdb_value;
        rs2_rdy_q[alloc_idx] <= bus.disp_rs2_rdy | rs2_cdb_hit;
        rs2_tag_q[alloc_idx] <= bus.disp_rs2_tag;
        rs2_val_q[alloc_idx] <= bus.disp_rs2_rdy ? bus.disp_rs2_val : bus.cdb_value;
        older_q[alloc_idx]   <= '0;
        for (int unsigned j = 0; j < RS_DEPTH; j++) begin
          if (j != 32'(alloc_idx)) older_q[j][alloc_idx] <= 1'b1;
        end
      end
      if (issue_load) begin
        issue_valid_q <= sel_found;
        if (sel_found) begin
          issue_type_q <= type_q[sel_idx];
          issue_info_q <= info_q[sel_idx];
          issue_rob_q  <= rob_q[sel_idx];
          issue_rs1_q  <= rs1_val_q[sel_idx];
          issue_rs2_q  <= rs2_val_q[sel_idx];
        end
      end
    end
  end

  assign bus.issue_valid           = issue_valid_q;
  assign bus.issue_arith_type      = issue_type_q;
  assign bus.issue_additional_info = issue_info_q;
  assign bus.issue_rob_entry       = issue_rob_q;
  assign bus.issue_rs1             = issue_rs1_q;
  assign bus.issue_rs2             = issue_rs2_q;
endmodule

// File: tb/tb_arith_reservation_station.sv
// Directed bench for arith_reservation_station: vector table for single ops, hand-written
// sequences for age ordering, backpressure, flush and asynchronous reset.
module tb_arith_reservation_station;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  arith_reservation_station_if #(.XLEN(32), .ROB_SIZE(256)) rs_if ();

  arith_reservation_station #(.XLEN(32), .ROB_SIZE(256), .RS_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rs_if.slave)
  );

  typedef struct {
    logic [2:0]  typ;
    logic        info;
    logic [7:0]  rob;
    logic        r1_rdy;
    logic [31:0] r1;
    logic        r2_rdy;
    logic [31:0] r2;
    logic        cdb_en;
    logic [7:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs_if.disp_valid = 1'b0;
    rs_if.cdb_valid  = 1'b0;
    rs_if.flush      = 1'b0;
  endtask

  // Operand args carry the value when ready, the producer tag otherwise.
  task automatic drive_disp(input logic [2:0] t, input logic i, input logic [7:0] rob,
                            input logic r1r, input logic [31:0] r1,
                            input logic r2r, input logic [31:0] r2);
    rs_if.disp_valid           = 1'b1;
    rs_if.disp_arith_type      = t;
    rs_if.disp_additional_info = i;
    rs_if.disp_rob_entry       = rob;
    rs_if.disp_rs1_rdy         = r1r;
    rs_if.disp_rs1_tag         = r1[7:0];
    rs_if.disp_rs1_val         = r1;
    rs_if.disp_rs2_rdy         = r2r;
    rs_if.disp_rs2_tag         = r2[7:0];
    rs_if.disp_rs2_val         = r2;
  endtask

  task automatic drive_cdb(input logic [7:0] tag, input logic [31:0] val);
    rs_if.cdb_valid     = 1'b1;
    rs_if.cdb_rob_entry = tag;
    rs_if.cdb_value     = val;
  endtask

  initial begin
    logic [7:0] age_order[8];
    vecs[0] = '{3'b000, 1'b1, 8'd5,   1'b1, 32'd10,         1'b1, 32'd3, 1'b0, 8'd0,  32'd0,
                32'd10, 32'd3};
    vecs[1] = '{3'b010, 1'b0, 8'd12,  1'b1, 32'hFFFF_FFFF,  1'b1, 32'd1, 1'b0, 8'd0,  32'd0,
                32'hFFFF_FFFF, 32'd1};
    vecs[2] = '{3'b011, 1'b0, 8'd200, 1'b0, 32'd40,         1'b1, 32'd7, 1'b1, 8'd40, 32'h1234,
                32'h1234, 32'd7};
    vecs[3] = '{3'b000, 1'b0, 8'd7,   1'b0, 32'd4,          1'b1, 32'd2, 1'b1, 8'd4,  32'h55,
                32'h55, 32'd2};
    vecs[4] = '{3'b000, 1'b1, 8'd100, 1'b0, 32'd50,         1'b0, 32'd50, 1'b1, 8'd50, 32'hCAFE,
                32'hCAFE, 32'hCAFE};
    age_order = '{8'd1, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};

    idle_inputs();
    drive_disp(3'b000, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    rs_if.disp_valid    = 1'b0;
    rs_if.cdb_rob_entry = '0;
    rs_if.cdb_value     = '0;
    rs_if.fu_ready      = 1'b1;
    tick();
    tick();
    check("reset issue_valid", 32'(rs_if.issue_valid), 32'd0);
    check("reset disp_ready", 32'(rs_if.disp_ready), 32'd1);
    check("reset issue_rob", 32'(rs_if.issue_rob_entry), 32'd0);
    check("reset issue_rs1", rs_if.issue_rs1, 32'd0);
    rst = 1'b0;
    tick();

    // Single-op vectors: dispatch at edge k, issue visible after edge k+1, drained after k+2.
    for (int v = 0; v < 5; v++) begin
      drive_disp(vecs[v].typ, vecs[v].info, vecs[v].rob, vecs[v].r1_rdy, vecs[v].r1,
                 vecs[v].r2_rdy, vecs[v].r2);
      if (vecs[v].cdb_en) drive_cdb(vecs[v].cdb_tag, vecs[v].cdb_val);
      tick();
      idle_inputs();
      check($sformatf("vec%0d early issue", v), 32'(rs_if.issue_valid), 32'd0);
      tick();
      check($sformatf("vec%0d issue_valid", v), 32'(rs_if.issue_valid), 32'd1);
      check($sformatf("vec%0d type", v), 32'(rs_if.issue_arith_type), 32'(vecs[v].typ));
      check($sformatf("vec%0d info", v), 32'(rs_if.issue_additional_info), 32'(vecs[v].info));
      check($sformatf("vec%0d rob", v), 32'(rs_if.issue_rob_entry), 32'(vecs[v].rob));
      check($sformatf("vec%0d rs1", v), rs_if.issue_rs1, vecs[v].exp_rs1);
      check($sformatf("vec%0d rs2", v), rs_if.issue_rs2, vecs[v].exp_rs2);
      tick();
      check($sformatf("vec%0d drained", v), 32'(rs_if.issue_valid), 32'd0);
    end

    // Wakeup two cycles after dispatch.
    drive_disp(3'b000, 1'b0, 8'd7, 1'b0, 32'd4, 1'b1, 32'd2);
    tick();
    idle_inputs();
    tick();
    check("wake waiting", 32'(rs_if.issue_valid), 32'd0);
    drive_cdb(8'd4, 32'h55);
    tick();
    idle_inputs();
    check("wake no bypass", 32'(rs_if.issue_valid), 32'd0);
    tick();
    check("wake issue_valid", 32'(rs_if.issue_valid), 32'd1);
    check("wake rs1", rs_if.issue_rs1, 32'h55);
    check("wake rs2", rs_if.issue_rs2, 32'd2);
    check("wake rob", 32'(rs_if.issue_rob_entry), 32'd7);
    tick();

    // Age order: rob 0..7 into slots 0..7, rob2 waits on tag 10, the rest on tag 9.
    for (int r = 0; r < 8; r++) begin
      drive_disp(3'b000, 1'b0, 8'(r), 1'b0, (r == 2) ? 32'd10 : 32'd9, 1'b1, 32'(r));
      tick();
    end
    idle_inputs();
    check("full disp_ready", 32'(rs_if.disp_ready), 32'd0);
    drive_cdb(8'd10, 32'hAA);
    tick();
    idle_inputs();
    tick();
    check("slot2 issue rob", 32'(rs_if.issue_rob_entry), 32'd2);
    check("slot2 issue rs1", rs_if.issue_rs1, 32'hAA);
    check("slot2 freed", 32'(rs_if.disp_ready), 32'd1);
    drive_disp(3'b010, 1'b0, 8'd8, 1'b0, 32'd9, 1'b1, 32'd8);
    tick();
    idle_inputs();
    check("refill full", 32'(rs_if.disp_ready), 32'd0);
    check("refill idle", 32'(rs_if.issue_valid), 32'd0);

    // Backpressure with the FU stalled while the station is full.
    rs_if.fu_ready = 1'b0;
    drive_cdb(8'd9, 32'h99);
    tick();
    idle_inputs();
    check("bp no bypass", 32'(rs_if.issue_valid), 32'd0);
    tick();
    check("bp first rob", 32'(rs_if.issue_rob_entry), 32'd0);
    check("bp first rs1", rs_if.issue_rs1, 32'h99);
    check("bp slot0 free", 32'(rs_if.disp_ready), 32'd1);
    drive_disp(3'b011, 1'b1, 8'd9, 1'b1, 32'd1, 1'b1, 32'd2);
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp hold%0d valid", c), 32'(rs_if.issue_valid), 32'd1);
      check($sformatf("bp hold%0d rob", c), 32'(rs_if.issue_rob_entry), 32'd0);
      check($sformatf("bp hold%0d full", c), 32'(rs_if.disp_ready), 32'd0);
      tick();
    end
    rs_if.fu_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      check($sformatf("age issue%0d valid", n), 32'(rs_if.issue_valid), 32'd1);
      check($sformatf("age issue%0d rob", n), 32'(rs_if.issue_rob_entry), 32'(age_order[n]));
      if (n == 0) check("release disp_ready", 32'(rs_if.disp_ready), 32'd1);
    end
    tick();
    check("age drained", 32'(rs_if.issue_valid), 32'd0);

    // Flush beats dispatch, wakeup and a pending issue.
    rs_if.fu_ready = 1'b0;
    drive_disp(3'b000, 1'b0, 8'd30, 1'b1, 32'd1, 1'b1, 32'd1);
    tick();
    drive_disp(3'b000, 1'b0, 8'd31, 1'b0, 32'd20, 1'b1, 32'd1);
    tick();
    check("pre-flush issue rob", 32'(rs_if.issue_rob_entry), 32'd30);
    drive_disp(3'b000, 1'b0, 8'd33, 1'b1, 32'd5, 1'b1, 32'd6);
    drive_cdb(8'd20, 32'h20);
    rs_if.flush = 1'b1;
    tick();
    idle_inputs();
    rs_if.fu_ready = 1'b1;
    check("flush issue_valid", 32'(rs_if.issue_valid), 32'd0);
    check("flush disp_ready", 32'(rs_if.disp_ready), 32'd1);
    drive_cdb(8'd20, 32'h21);
    tick();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("flush quiet%0d", c), 32'(rs_if.issue_valid), 32'd0);
    end

    // Asynchronous reset mid-traffic.
    rs_if.fu_ready = 1'b0;
    drive_disp(3'b000, 1'b1, 8'd40, 1'b1, 32'd11, 1'b1, 32'd12);
    tick();
    drive_disp(3'b000, 1'b0, 8'd41, 1'b0, 32'd60, 1'b1, 32'd1);
    tick();
    idle_inputs();
    check("pre-reset issue", 32'(rs_if.issue_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async reset issue_valid", 32'(rs_if.issue_valid), 32'd0);
    check("async reset disp_ready", 32'(rs_if.disp_ready), 32'd1);
    check("async reset rob", 32'(rs_if.issue_rob_entry), 32'd0);
    tick();
    rst = 1'b0;
    rs_if.fu_ready = 1'b1;
    drive_cdb(8'd60, 32'h60);
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post-reset quiet%0d", c), 32'(rs_if.issue_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
